// File: rtl/traffic_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// traffic_pkg : phase encodings and lamp-vector helpers shared by the monitor
// Revision    : 1.0
// ---------------------------------------------------------------------------
package traffic_pkg;

  typedef enum logic [1:0] {
    PH_SYNC   = 2'd0,
    PH_GREEN  = 2'd1,
    PH_YELLOW = 2'd2,
    PH_RED    = 2'd3
  } phase_e;

  // Bit positions inside the {red, green, yellow} lamp vector
  localparam int unsigned C_LAMP_RED    = 2;
  localparam int unsigned C_LAMP_GREEN  = 1;
  localparam int unsigned C_LAMP_YELLOW = 0;
  localparam int unsigned C_LAMP_W      = 3;
  localparam int unsigned C_DWELL_W     = 8;

  function automatic logic lamps_onehot(input logic [C_LAMP_W-1:0] lamps);
    return (lamps == 3'b001) || (lamps == 3'b010) || (lamps == 3'b100);
  endfunction

  function automatic phase_e lamps_to_phase(input logic [C_LAMP_W-1:0] lamps);
    if (lamps[C_LAMP_RED])         return PH_RED;
    else if (lamps[C_LAMP_GREEN])  return PH_GREEN;
    else if (lamps[C_LAMP_YELLOW]) return PH_YELLOW;
    else                           return PH_SYNC;
  endfunction

  function automatic phase_e next_phase(input phase_e p);
    case (p)
      PH_GREEN:  return PH_YELLOW;
      PH_YELLOW: return PH_RED;
      PH_RED:    return PH_GREEN;
      default:   return PH_SYNC;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/dwell_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dwell_counter : saturating run-length counter, load forces the count to 1
// Revision      : 1.0
// ---------------------------------------------------------------------------
module dwell_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load)
      count_d = WIDTH'(1);
    else if (enable && (count_q != '1))
      count_d = count_q + WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/traffic_light_monitor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// traffic_light_monitor : checks lamp order and per-phase dwell times
// Revision              : 1.0
// ---------------------------------------------------------------------------
module traffic_light_monitor
  import traffic_pkg::*;
#(
  parameter int unsigned GREENTIMER  = 6,
  parameter int unsigned YELLOWTIMER = 2,
  parameter int unsigned REDTIMER    = 8
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       red,
  input  logic       green,
  input  logic       yellow,
  output logic [1:0] phase,
  output logic       locked,
  output logic       err_illegal,
  output logic       err_order,
  output logic       err_timing,
  output logic       err_any,
  output logic [7:0] cycle_count
);

  logic [C_LAMP_W-1:0]  lamps;
  logic [C_LAMP_W-1:0]  lamps_q;
  logic [C_DWELL_W-1:0] dwell;
  logic                 dwell_load;
  phase_e               target;

  phase_e     phase_q,       phase_d;
  logic       checked_q,     checked_d;
  logic       locked_q,      locked_d;
  logic       illegal_q,     illegal_d;
  logic       order_q,       order_d;
  logic       timing_q,      timing_d;
  logic       any_q,         any_d;
  logic [7:0] cycle_count_q, cycle_count_d;

  function automatic logic [C_DWELL_W-1:0] phase_timer(input phase_e p);
    case (p)
      PH_GREEN:  return C_DWELL_W'(GREENTIMER);
      PH_YELLOW: return C_DWELL_W'(YELLOWTIMER);
      PH_RED:    return C_DWELL_W'(REDTIMER);
      default:   return '0;
    endcase
  endfunction

  always_comb begin
    lamps                = '0;
    lamps[C_LAMP_RED]    = red;
    lamps[C_LAMP_GREEN]  = green;
    lamps[C_LAMP_YELLOW] = yellow;
  end

  assign dwell_load = (lamps != lamps_q);
  assign target     = lamps_to_phase(lamps);

  dwell_counter #(
    .WIDTH (C_DWELL_W)
  ) u_dwell (
    .clk    (clk),
    .rstn   (rstn),
    .load   (dwell_load),
    .enable (1'b1),
    .count  (dwell)
  );

  always_comb begin
    phase_d       = phase_q;
    checked_d     = checked_q;
    locked_d      = locked_q;
    illegal_d     = 1'b0;
    order_d       = 1'b0;
    timing_d      = 1'b0;
    cycle_count_d = cycle_count_q;
    any_d         = any_q | illegal_q | order_q | timing_q;

    if (!lamps_onehot(lamps)) begin
      phase_d   = PH_SYNC;
      checked_d = 1'b0;
      locked_d  = 1'b0;
      illegal_d = 1'b1;
    end else if (phase_q == PH_SYNC) begin
      phase_d   = target;
      checked_d = 1'b0;
    end else if (target == phase_q) begin
      // dwell still holds the previous count, so equality means this edge is TIMER+1
      timing_d = checked_q && (dwell == phase_timer(phase_q));
    end else if (target == next_phase(phase_q)) begin
      timing_d  = checked_q && (dwell < phase_timer(phase_q));
      phase_d   = target;
      checked_d = 1'b1;
      locked_d  = 1'b1;
      if (phase_q == PH_RED)
        cycle_count_d = cycle_count_q + 8'd1;
    end else begin
      order_d   = 1'b1;
      phase_d   = target;
      checked_d = 1'b0;
      locked_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lamps_q       <= '0;
      phase_q       <= PH_SYNC;
      checked_q     <= 1'b0;
      locked_q      <= 1'b0;
      illegal_q     <= 1'b0;
      order_q       <= 1'b0;
      timing_q      <= 1'b0;
      any_q         <= 1'b0;
      cycle_count_q <= 8'd0;
    end else begin
      lamps_q       <= lamps;
      phase_q       <= phase_d;
      checked_q     <= checked_d;
      locked_q      <= locked_d;
      illegal_q     <= illegal_d;
      order_q       <= order_d;
      timing_q      <= timing_d;
      any_q         <= any_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  assign phase       = phase_q;
  assign locked      = locked_q;
  assign err_illegal = illegal_q;
  assign err_order   = order_q;
  assign err_timing  = timing_q;
  assign err_any     = any_q;
  assign cycle_count = cycle_count_q;

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_monitor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_traffic_light_monitor : directed lamp sequences checked against a model
// Revision                 : 1.0
// ---------------------------------------------------------------------------
module tb_traffic_light_monitor;

  localparam int G_T = 6;
  localparam int Y_T = 2;
  localparam int R_T = 8;

  localparam logic [2:0] V_R  = 3'b100;
  localparam logic [2:0] V_G  = 3'b010;
  localparam logic [2:0] V_Y  = 3'b001;
  localparam logic [2:0] V_RG = 3'b110;

  logic       clk    = 1'b0;
  logic       rstn   = 1'b0;
  logic       red    = 1'b0;
  logic       green  = 1'b0;
  logic       yellow = 1'b0;
  logic [1:0] phase;
  logic       locked;
  logic       err_illegal;
  logic       err_order;
  logic       err_timing;
  logic       err_any;
  logic [7:0] cycle_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: tracked phase as 0..3, run length of the current lamp vector
  int         m_phase   = 0;
  int         m_checked = 0;
  int         m_locked  = 0;
  int         m_run     = 0;
  int         m_cycles  = 0;
  int         m_ill     = 0;
  int         m_ord     = 0;
  int         m_tim     = 0;
  int         m_any     = 0;
  logic [2:0] m_prev    = 3'b000;

  always #5 clk = ~clk;

  traffic_light_monitor #(
    .GREENTIMER  (G_T),
    .YELLOWTIMER (Y_T),
    .REDTIMER    (R_T)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .red         (red),
    .green       (green),
    .yellow      (yellow),
    .phase       (phase),
    .locked      (locked),
    .err_illegal (err_illegal),
    .err_order   (err_order),
    .err_timing  (err_timing),
    .err_any     (err_any),
    .cycle_count (cycle_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int timer_of(input int p);
    case (p)
      1:       return G_T;
      2:       return Y_T;
      3:       return R_T;
      default: return 0;
    endcase
  endfunction

  function automatic int phase_of(input logic [2:0] v);
    if (v == V_R) return 3;
    if (v == V_G) return 1;
    if (v == V_Y) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_checked = 0; m_locked = 0; m_run = 0; m_cycles = 0;
    m_ill = 0; m_ord = 0; m_tim = 0; m_any = 0; m_prev = 3'b000;
  endtask

  task automatic model_step(input logic [2:0] v);
    int run_next;
    int tgt;
    m_any    = (m_any | m_ill | m_ord | m_tim) != 0 ? 1 : 0;
    m_ill    = 0; m_ord = 0; m_tim = 0;
    run_next = (v != m_prev) ? 1 : m_run + 1;
    tgt      = phase_of(v);
    if ($countones(v) != 1) begin
      m_ill = 1; m_phase = 0; m_checked = 0; m_locked = 0;
    end else if (m_phase == 0) begin
      m_phase = tgt; m_checked = 0;
    end else if (tgt == m_phase) begin
      if (m_checked == 1 && run_next == timer_of(m_phase) + 1) m_tim = 1;
    end else if (tgt == (m_phase % 3) + 1) begin
      if (m_checked == 1 && m_run < timer_of(m_phase)) m_tim = 1;
      if (m_phase == 3) m_cycles = (m_cycles + 1) % 256;
      m_phase = tgt; m_checked = 1; m_locked = 1;
    end else begin
      m_ord = 1; m_phase = tgt; m_checked = 0; m_locked = 0;
    end
    m_prev = v;
    m_run  = run_next;
  endtask

  // Single compare process: advance the model on each edge, check 1 time unit later
  always @(posedge clk) begin
    if (!rstn) model_reset();
    else       model_step({red, green, yellow});
    #1;
    chk("phase",       32'(phase),       m_phase);
    chk("locked",      32'(locked),      m_locked);
    chk("err_illegal", 32'(err_illegal), m_ill);
    chk("err_order",   32'(err_order),   m_ord);
    chk("err_timing",  32'(err_timing),  m_tim);
    chk("err_any",     32'(err_any),     m_any);
    chk("cycle_count", 32'(cycle_count), m_cycles);
  end

  task automatic tick(input logic [2:0] v);
    {red, green, yellow} = v;
    @(posedge clk);
    #2;
  endtask

  task automatic hold(input logic [2:0] v, input int n);
    for (int i = 0; i < n; i++) tick(v);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_phase"},  32'(phase),       0);
    chk({tag, "_locked"}, 32'(locked),      0);
    chk({tag, "_ill"},    32'(err_illegal), 0);
    chk({tag, "_ord"},    32'(err_order),   0);
    chk({tag, "_tim"},    32'(err_timing),  0);
    chk({tag, "_any"},    32'(err_any),     0);
    chk({tag, "_count"},  32'(cycle_count), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2;
    chk_all_zero("reset");
    rstn = 1'b1;

    // Three clean cycles at the nominal timing
    tick(V_G);
    chk("first_green_phase",  32'(phase),  1);
    chk("first_green_locked", 32'(locked), 0);
    hold(V_G, G_T - 1);
    tick(V_Y);
    chk("first_change_locked", 32'(locked), 1);
    hold(V_Y, Y_T - 1);
    hold(V_R, R_T);
    for (int c = 0; c < 2; c++) begin
      hold(V_G, G_T);
      hold(V_Y, Y_T);
      hold(V_R, R_T);
    end
    hold(V_G, G_T);
    chk("clean_count",  32'(cycle_count), 3);
    chk("clean_errany", 32'(err_any),     0);
    chk("clean_locked", 32'(locked),      1);

    // Green overstays by one edge; no extra pulse when it finally changes
    tick(V_G);
    chk("overstay_pulse", 32'(err_timing), 1);
    tick(V_Y);
    chk("overstay_exit",  32'(err_timing), 0);
    chk("errany_set",     32'(err_any),    1);

    // Yellow held for a single edge, then red
    tick(V_R);
    chk("short_yellow_tim",   32'(err_timing), 1);
    chk("short_yellow_phase", 32'(phase),      3);

    // Checked green skips straight to red
    hold(V_R, R_T - 1);
    tick(V_G);
    chk("count_after_short", 32'(cycle_count), 4);
    hold(V_G, 2);
    tick(V_R);
    chk("skip_order",  32'(err_order),  1);
    chk("skip_timing", 32'(err_timing), 0);
    chk("skip_locked", 32'(locked),     0);
    chk("skip_phase",  32'(phase),      3);
    hold(V_R, 3);

    // Two illegal vectors in a row
    tick(V_RG);
    chk("illegal1", 32'(err_illegal), 1);
    tick(V_RG);
    chk("illegal2",       32'(err_illegal), 1);
    chk("illegal_phase",  32'(phase),       0);
    chk("illegal_count",  32'(cycle_count), 4);
    chk("illegal_errany", 32'(err_any),     1);

    // Rebuild to cycle_count 5 and stop mid-red
    hold(V_Y, 2);
    hold(V_R, R_T);
    hold(V_G, G_T);
    hold(V_Y, Y_T);
    hold(V_R, 3);
    chk("pre_reset_count", 32'(cycle_count), 5);
    chk("pre_reset_phase", 32'(phase),       3);

    // Asynchronous reset between clock edges
    #3;
    rstn = 1'b0;
    #1;
    chk_all_zero("async");
    @(posedge clk);
    #2;
    rstn = 1'b1;

    // First red after release is partial: no overstay pulse at edge R_T+1
    hold(V_R, R_T);
    tick(V_R);
    chk("post_reset_tim",    32'(err_timing), 0);
    chk("post_reset_phase",  32'(phase),      3);
    chk("post_reset_locked", 32'(locked),     0);
    tick(V_G);
    chk("post_reset_count",  32'(cycle_count), 1);
    chk("post_reset_lock2",  32'(locked),      1);
    chk("post_reset_errany", 32'(err_any),     0);
    hold(V_G, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/traffic_light_monitor.md
TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

Interface
REQ-001 Parameter GREENTIMER, default 6, green dwell in clock cycles (legal 1..254).
REQ-002 Parameter YELLOWTIMER, default 2, yellow dwell in clock cycles (legal 1..254).
REQ-003 Parameter REDTIMER, default 8, red dwell in clock cycles (legal 1..254).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rstn  input  1  reset, asynchronous, active-low.
REQ-006 red  input  1  observed red lamp, synchronous to clk.
REQ-007 green  input  1  observed green lamp, synchronous to clk.
REQ-008 yellow  input  1  observed yellow lamp, synchronous to clk.
REQ-009 phase  output  2  current tracked phase: 0 SYNC, 1 GREEN, 2 YELLOW, 3 RED.
REQ-010 locked  output  1  high once the monitor has observed one legal transition since the last SYNC.
REQ-011 err_illegal  output  1  one-cycle pulse: lamp vector not one-hot.
REQ-012 err_order  output  1  one-cycle pulse: legal lamp change out of sequence.
REQ-013 err_timing  output  1  one-cycle pulse: checked phase dwell differs from its TIMER.
REQ-014 err_any  output  1  sticky OR of all error pulses, cleared only by reset.
REQ-015 cycle_count  output  8  number of completed RED->GREEN transitions, wraps 255->0.

Function
REQ-016 All outputs SHALL be registered; each is updated at the rising edge that samples the causing lamp vector.
REQ-017 FSM states SHALL be SYNC, GREEN, YELLOW, RED; the only legal sequence is GREEN->YELLOW->RED->GREEN.
REQ-018 A dwell counter (8 bits, saturating at 255) SHALL count consecutive edges with an unchanged lamp vector; it loads 1 on every lamp change.
REQ-019 In SYNC, the first one-hot vector SHALL move to the matching state with that phase marked unchecked (partial dwell); locked stays low.
REQ-020 On a legal-order change, err_timing SHALL pulse if the departing phase was checked and its dwell count is below its TIMER; the new phase is checked; locked SHALL go high.
REQ-021 While in a checked phase, when dwell reaches TIMER+1, err_timing SHALL pulse once; no further timing pulse for that phase, including at its exit.
REQ-022 On an out-of-order one-hot change, err_order SHALL pulse, the FSM SHALL jump to the matching state as unchecked, and locked SHALL drop.
REQ-023 A non-one-hot vector (zero or multiple lamps) SHALL pulse err_illegal on every such edge, force SYNC, clear locked; cycle_count is held.
REQ-024 cycle_count SHALL increment on each legal RED->GREEN change regardless of timing errors.
REQ-025 Simultaneous conditions: err_order and err_timing SHALL never both pulse on one edge; order error takes precedence.
REQ-026 err_any SHALL assert on the edge after any error pulse and hold until reset.

Reset
REQ-027 Asserting rstn low SHALL immediately force phase=0 (SYNC), locked=0, all err_* =0, cycle_count=0, dwell=0, independent of clk.
REQ-028 Reset release mid-sequence SHALL resume monitoring from SYNC at the first edge with rstn high; the first phase after release is unchecked.

Structure
REQ-029 Phase encodings (SYNC/GREEN/YELLOW/RED) and the red/green/yellow lamp-vector ordering SHALL live in shared package traffic_pkg, also used by traffic_lights.
REQ-030 The saturating dwell counter SHALL be a sub-module dwell_counter (load, enable, 8-bit count out); everything else stays in traffic_light_monitor.

Verification
REQ-031 Drive traffic_lights (6/2/8) into the monitor for 3 full cycles -> no error pulses, locked high after first change, cycle_count=3, err_any=0.
REQ-032 Hold green 7 cycles in a checked GREEN -> err_timing pulses on the 7th edge only; no pulse at the green->yellow change.
REQ-033 Checked yellow for 1 cycle then red -> err_timing pulses at the red edge; phase=3.
REQ-034 From checked GREEN, switch straight to red -> err_order pulses, err_timing does not, locked=0, phase=3.
REQ-035 Drive red=green=1 for 2 cycles -> err_illegal pulses twice, phase=0, cycle_count unchanged; err_any stays 1.
REQ-036 Assert rstn low mid-RED with cycle_count=5 -> all outputs zero immediately, no clock needed; after release first red dwell is not timing-checked.
